// File: rtl/uart_pkg.sv
// Shared UART frame constants, FSM state encodings and parity helper
// for the command responder slice.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam logic        RW_WRITE  = 1'b1;

    // Command FSM encodings
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_RX_CMD    = 4'd1;
    localparam logic [3:0] S_RX_DATA   = 4'd2;
    localparam logic [3:0] S_WR_STB    = 4'd3;
    localparam logic [3:0] S_RD_REQ    = 4'd4;
    localparam logic [3:0] S_RD_CAP    = 4'd5;
    localparam logic [3:0] S_TX_START  = 4'd6;
    localparam logic [3:0] S_TX_DATA   = 4'd7;
    localparam logic [3:0] S_TX_PARITY = 4'd8;
    localparam logic [3:0] S_TX_STOP   = 4'd9;

    // Byte receiver encodings
    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_PAR   = 3'd3;
    localparam logic [2:0] R_STOP  = 3'd4;

    function automatic logic even_par(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: rx synchronizer, start-glitch filter, mid-bit sampler
// and parity/stop check. Held idle while rx_en is low.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned BR = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_en,
    output logic                 start_det,
    output logic                 glitch,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 byte_vld,
    output logic                 byte_err
);

    localparam int unsigned CW = (BR > 2) ? $clog2(BR) : 1;
    localparam logic [CW-1:0] HALF = CW'(BR / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BR - 1);

    logic                 rx_s1, rx_s2, rx_d;
    logic                 fall;
    logic [2:0]           r_state;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] sh;
    logic                 par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall = rx_d & ~rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            par       <= 1'b0;
            start_det <= 1'b0;
            glitch    <= 1'b0;
            byte_vld  <= 1'b0;
            byte_err  <= 1'b0;
            byte_data <= '0;
        end else begin
            start_det <= 1'b0;
            glitch    <= 1'b0;
            byte_vld  <= 1'b0;
            byte_err  <= 1'b0;
            if (!rx_en) begin
                r_state <= R_IDLE;
                cnt     <= '0;
            end else begin
                case (r_state)
                    R_IDLE: begin
                        if (fall) begin
                            r_state   <= R_START;
                            cnt       <= '0;
                            start_det <= 1'b1;
                        end
                    end
                    R_START: begin
                        if (cnt == HALF) begin
                            cnt <= '0;
                            // Line back high at mid start bit: treat as noise
                            if (rx_s2 != START_BIT) begin
                                r_state <= R_IDLE;
                                glitch  <= 1'b1;
                            end else begin
                                r_state <= R_DATA;
                                idx     <= '0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    R_DATA: begin
                        if (cnt == FULL) begin
                            cnt <= '0;
                            sh  <= {rx_s2, sh[DATA_BITS-1:1]};
                            if (idx == 3'd7) r_state <= R_PAR;
                            else             idx     <= idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    R_PAR: begin
                        if (cnt == FULL) begin
                            cnt     <= '0;
                            par     <= rx_s2;
                            r_state <= R_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    R_STOP: begin
                        if (cnt == FULL) begin
                            cnt     <= '0;
                            r_state <= R_IDLE;
                            if ((rx_s2 != STOP_BIT) || (even_par(sh) ^ par)) begin
                                byte_err <= 1'b1;
                            end else begin
                                byte_vld  <= 1'b1;
                                byte_data <= sh;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: r_state <= R_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// UART command responder: decodes write/read command frames into local
// register strobes and returns read data as a UART frame on tx.
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int unsigned BR         = 434,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned GAP_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  tx,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int unsigned TW = $clog2(BR * GAP_BITS + 1);
    localparam logic [TW-1:0] BIT_END = TW'(BR - 1);
    localparam logic [TW-1:0] GAP_END = TW'(BR * GAP_BITS - 1);

    logic [3:0]           state;
    logic [TW-1:0]        tmr;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;
    logic [2:0]           tx_idx;
    logic                 data_started;
    logic                 rx_en;
    logic                 start_det, glitch, byte_vld, byte_err;
    logic [DATA_BITS-1:0] byte_data;

    // Half-duplex: receiver is held idle outside the receive phases
    assign rx_en = (state == S_IDLE) || (state == S_RX_CMD) || (state == S_RX_DATA);
    assign busy  = (state != S_IDLE);

    uart_byte_rx #(.BR(BR)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_en     (rx_en),
        .start_det (start_det),
        .glitch    (glitch),
        .byte_data (byte_data),
        .byte_vld  (byte_vld),
        .byte_err  (byte_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            tx           <= 1'b1;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            reg_wr       <= 1'b0;
            reg_rd       <= 1'b0;
            frame_err    <= 1'b0;
            tmr          <= '0;
            tx_sh        <= '0;
            tx_par       <= 1'b0;
            tx_idx       <= '0;
            data_started <= 1'b0;
        end else begin
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= STOP_BIT;
                    if (start_det) state <= S_RX_CMD;
                end
                S_RX_CMD: begin
                    if (byte_err) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (glitch) begin
                        state <= S_IDLE;
                    end else if (byte_vld) begin
                        reg_addr     <= byte_data[ADDR_WIDTH-1:0];
                        tmr          <= '0;
                        data_started <= 1'b0;
                        if (byte_data[7] == RW_WRITE) begin
                            state <= S_RX_DATA;
                        end else begin
                            reg_rd <= 1'b1;
                            state  <= S_RD_REQ;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (byte_err) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (byte_vld) begin
                        reg_wdata <= byte_data;
                        reg_wr    <= 1'b1;
                        state     <= S_WR_STB;
                    end else begin
                        // Gap timer pauses while a data frame is in flight
                        if (start_det)   data_started <= 1'b1;
                        else if (glitch) data_started <= 1'b0;
                        if (!data_started && !start_det) begin
                            if (tmr == GAP_END) begin
                                frame_err <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                tmr <= tmr + 1'b1;
                            end
                        end
                    end
                end
                S_WR_STB: state <= S_IDLE;
                S_RD_REQ: state <= S_RD_CAP;
                S_RD_CAP: begin
                    tx_sh  <= reg_rdata;
                    tx_par <= even_par(reg_rdata);
                    tx     <= START_BIT;
                    tmr    <= '0;
                    state  <= S_TX_START;
                end
                S_TX_START: begin
                    if (tmr == BIT_END) begin
                        tmr    <= '0;
                        tx     <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_idx <= '0;
                        state  <= S_TX_DATA;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_TX_DATA: begin
                    if (tmr == BIT_END) begin
                        tmr <= '0;
                        if (tx_idx == 3'd7) begin
                            tx    <= tx_par;
                            state <= S_TX_PARITY;
                        end else begin
                            tx     <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_TX_PARITY: begin
                    if (tmr == BIT_END) begin
                        tmr   <= '0;
                        tx    <= STOP_BIT;
                        state <= S_TX_STOP;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_TX_STOP: begin
                    if (tmr == BIT_END) begin
                        tmr   <= '0;
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: begin
                    tx    <= STOP_BIT;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed self-checking bench for uart_cmd_responder (BR=16, GAP_BITS=4).
module tb_uart_cmd_responder;

    localparam int BR = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       tx;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, tx_low_cnt = 0;
    logic [7:0] wr_data_seen = '0;
    logic [6:0] wr_addr_seen = '0;
    int w0, r0, e0, t0;

    uart_cmd_responder #(.BR(16), .ADDR_WIDTH(7), .DATA_WIDTH(8), .GAP_BITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .tx        (tx),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt++;
            wr_data_seen = reg_wdata;
            wr_addr_seen = reg_addr;
        end
        if (reg_rd) rd_cnt++;
        if (frame_err) err_cnt++;
        if (!tx) tx_low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] bits;
        bits = {1'b1, (^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (BR) @(negedge clk);
        end
    endtask

    task automatic do_read(input string tag, input logic [6:0] addr, input logic [7:0] d);
        logic [10:0] exp_bits;
        logic        found;
        int          r_base;
        reg_rdata = d;
        r_base    = rd_cnt;
        send_frame({1'b0, addr}, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (!tx) found = 1'b1;
        end
        chk({tag, "_tx_start_seen"}, found, 1'b1);
        chk({tag, "_rd_count"}, rd_cnt - r_base, 1);
        chk({tag, "_addr"}, reg_addr, addr);
        exp_bits = {1'b1, ^d, d, 1'b0};
        repeat (7) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("%s_txbit%0d", tag, i), tx, exp_bits[i]);
            if (i < 10) repeat (BR) @(negedge clk);
        end
        repeat (BR) @(negedge clk);
        chk({tag, "_idle_after"}, busy, 1'b0);
    endtask

    initial begin
        logic found;
        int   t;
        rst_n     = 1'b0;
        rx        = 1'b1;
        reg_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_addr", reg_addr, 7'h00);
        chk("rst_wdata", reg_wdata, 8'h00);
        chk("rst_wr", reg_wr, 1'b0);
        chk("rst_rd", reg_rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write 0x3C to address 0x05
        w0 = wr_cnt; e0 = err_cnt; t0 = tx_low_cnt;
        send_frame(8'h85, 1'b0);
        chk("wr_busy_between", busy, 1'b1);
        send_frame(8'h3C, 1'b0);
        repeat (30) @(negedge clk);
        chk("wr_count", wr_cnt - w0, 1);
        chk("wr_strobe_addr", wr_addr_seen, 7'h05);
        chk("wr_strobe_data", wr_data_seen, 8'h3C);
        chk("wr_addr_held", reg_addr, 7'h05);
        chk("wr_wdata_held", reg_wdata, 8'h3C);
        chk("wr_tx_quiet", tx_low_cnt - t0, 0);
        chk("wr_no_err", err_cnt - e0, 0);
        chk("wr_idle", busy, 1'b0);

        // Read 0x12 returning 0xA7
        do_read("rd1", 7'h12, 8'hA7);

        // Parity error on command byte
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(8'h85, 1'b1);
        repeat (20) @(negedge clk);
        chk("par_err_pulse", err_cnt - e0, 1);
        chk("par_no_wr", wr_cnt - w0, 0);
        chk("par_idle", busy, 1'b0);

        // Gap timeout after write byte0
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(8'h85, 1'b0);
        found = 1'b0;
        t = 0;
        for (int i = 1; i <= 100 && !found; i++) begin
            @(negedge clk);
            if (frame_err) begin
                found = 1'b1;
                t = i;
            end
        end
        chk("gap_err_seen", found, 1'b1);
        chk("gap_err_time", (t >= 56 && t <= 64), 1'b1);
        repeat (10) @(negedge clk);
        chk("gap_err_once", err_cnt - e0, 1);
        chk("gap_no_wr", wr_cnt - w0, 0);
        chk("gap_idle", busy, 1'b0);

        // Start-bit glitch
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_err", err_cnt - e0, 0);
        chk("glitch_no_wr", wr_cnt - w0, 0);
        chk("glitch_no_rd", rd_cnt - r0, 0);
        chk("glitch_idle", busy, 1'b0);
        do_read("rd2", 7'h21, 8'h5A);

        // Reset during TX_DATA
        reg_rdata = 8'h00;
        send_frame(8'h40, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (!tx) found = 1'b1;
        end
        chk("rst_mid_tx_start", found, 1'b1);
        repeat (40) @(negedge clk);
        chk("rst_mid_pre_tx", tx, 1'b0);
        chk("rst_mid_pre_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_addr", reg_addr, 7'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_read("rd3", 7'h7F, 8'h96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
